// File: rtl/seven_seg_scan_ctrl_if.sv
// Update handshake between application logic and the 7-segment scan controller.
// The master supplies a display value; the slave raises ready while its pending slot is empty.
interface seven_seg_scan_ctrl_if;
  localparam int unsigned VALUE_W = 16;
  localparam int unsigned DIGITS  = 4;

  logic               upd_valid_i;
  logic               upd_ready_o;
  logic [VALUE_W-1:0] value_i;
  logic [DIGITS-1:0]  dp_i;
  logic               lzb_en_i;

  modport master (
    output upd_valid_i,
    output value_i,
    output dp_i,
    output lzb_en_i,
    input  upd_ready_o
  );

  modport slave (
    input  upd_valid_i,
    input  value_i,
    input  dp_i,
    input  lzb_en_i,
    output upd_ready_o
  );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scanner with anti-ghosting blank gaps.
// Display updates are staged in a one-entry slot and applied only on frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int unsigned CLK_FREQ_HZ  = 27_000_000,
  parameter int unsigned REFRESH_HZ   = 250,
  parameter int unsigned BLANK_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  seven_seg_scan_ctrl_if.slave        upd,
  output logic [3:0]                  digit_en_o,
  output logic [6:0]                  seg_o,
  output logic                        dp_o,
  output logic                        frame_done_o
);

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned SEG_W       = 7;
  localparam int unsigned VALUE_W     = 16;
  localparam int unsigned DIGIT_TICKS = CLK_FREQ_HZ / (DIGITS * REFRESH_HZ);
  localparam int unsigned TICK_W      = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;

  if (DIGIT_TICKS <= BLANK_CYCLES) begin : g_bad_timing
    $error("seven_seg_scan_ctrl: DIGIT_TICKS must exceed BLANK_CYCLES");
  end

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  typedef struct packed {
    logic [VALUE_W-1:0] value;
    logic [DIGITS-1:0]  dp;
    logic               lzb;
  } disp_t;

  state_t             state_q, state_nxt;
  logic [TICK_W-1:0]  tick_q, tick_nxt;
  logic [1:0]         dig_q, dig_nxt;
  disp_t              act_q, act_nxt;
  disp_t              pend_q, pend_nxt;
  logic               pend_full_q, pend_full_nxt;
  logic               ready_q, ready_nxt;
  logic [DIGITS-1:0]  en_nxt;
  logic [SEG_W-1:0]   seg_nxt;
  logic               dp_nxt;
  logic               frame_end;
  logic               accept;
  logic [DIGITS-1:0][3:0] nib;
  logic [DIGITS-1:0]  lead_zero;

  function automatic logic [SEG_W-1:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  assign upd.upd_ready_o = ready_q;

  // Scan sequencing, update staging and next-output computation
  always_comb begin
    tick_nxt      = tick_q + TICK_W'(1);
    dig_nxt       = dig_q;
    act_nxt       = act_q;
    pend_nxt      = pend_q;
    pend_full_nxt = pend_full_q;
    en_nxt        = '0;
    seg_nxt       = '0;
    dp_nxt        = 1'b0;

    frame_end = (tick_q == TICK_W'(DIGIT_TICKS - 1)) && (dig_q == 2'd3);
    accept    = upd.upd_valid_i && ready_q;

    if (tick_q == TICK_W'(DIGIT_TICKS - 1)) begin
      tick_nxt = '0;
      dig_nxt  = dig_q + 2'd1;
    end
    state_nxt = (tick_nxt < TICK_W'(BLANK_CYCLES)) ? ST_BLANK : ST_DRIVE;

    // Ready is only high with the slot empty, so promote and accept never coincide
    if (frame_end && pend_full_q) begin
      act_nxt       = pend_q;
      pend_full_nxt = 1'b0;
    end
    if (accept) begin
      pend_nxt      = '{value: upd.value_i, dp: upd.dp_i, lzb: upd.lzb_en_i};
      pend_full_nxt = 1'b1;
    end
    ready_nxt = !pend_full_nxt;

    nib          = act_q.value;
    lead_zero[3] = (nib[3] == 4'h0);
    lead_zero[2] = lead_zero[3] && (nib[2] == 4'h0);
    lead_zero[1] = lead_zero[2] && (nib[1] == 4'h0);
    lead_zero[0] = 1'b0;

    case (state_q)
      ST_DRIVE: begin
        en_nxt  = 4'b0001 << dig_q;
        seg_nxt = (act_q.lzb && lead_zero[dig_q]) ? '0 : hex7(nib[dig_q]);
        dp_nxt  = act_q.dp[dig_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      tick_q       <= '0;
      dig_q        <= '0;
      act_q        <= '0;
      pend_q       <= '0;
      pend_full_q  <= 1'b0;
      ready_q      <= 1'b0;
      digit_en_o   <= '0;
      seg_o        <= '0;
      dp_o         <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      tick_q       <= tick_nxt;
      dig_q        <= dig_nxt;
      act_q        <= act_nxt;
      pend_q       <= pend_nxt;
      pend_full_q  <= pend_full_nxt;
      ready_q      <= ready_nxt;
      digit_en_o   <= en_nxt;
      seg_o        <= seg_nxt;
      dp_o         <= dp_nxt;
      frame_done_o <= frame_end;
    end
  end

endmodule
